// File: rtl/pdm_pkg.sv
// Shared PDM constants and CIC sizing helpers, used by the decimator and the modulator.
package pdm_pkg;

   localparam int CIC_ORDER = 3;
   localparam int OSR_LOG2  = 6;
   localparam int PCM_W     = 16;

   function automatic int cic_width(input int osr_log2);
      return 1 + CIC_ORDER * osr_log2;
   endfunction

   function automatic int out_shift(input int osr_log2);
      return CIC_ORDER * osr_log2 - PCM_W;
   endfunction

endpackage

// File: rtl/pdm_in_sync.sv
// Flop chain carrying the PDM bit and its strobe together; STAGES cycles of latency, 0 = bypass.
module pdm_in_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bit_i,
   input  logic en_i,
   output logic bit_o,
   output logic en_o
);

   generate
      if (STAGES == 0) begin : g_bypass
         assign bit_o = bit_i;
         assign en_o  = en_i;
      end else begin : g_chain
         logic [STAGES-1:0] bit_q;
         logic [STAGES-1:0] en_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               bit_q <= '0;
               en_q  <= '0;
            end else begin
               bit_q[0] <= bit_i;
               en_q[0]  <= en_i;
               for (int k = 1; k < STAGES; k++) begin
                  bit_q[k] <= bit_q[k-1];
                  en_q[k]  <= en_q[k-1];
               end
            end
         end

         assign bit_o = bit_q[STAGES-1];
         assign en_o  = en_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/pdm_decimator.sv
// sinc^3 CIC decimator turning a strobed 1-bit PDM stream into 16-bit unsigned PCM.
// pcm_valid pulses two cycles after the strobe that completes a frame; no backpressure.
module pdm_decimator #(
   parameter int OSR_LOG2    = pdm_pkg::OSR_LOG2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pdm_in,
   input  logic                     pdm_en,
   output logic [pdm_pkg::PCM_W-1:0] pcm,
   output logic                     pcm_valid,
   output logic                     pcm_settled
);

   import pdm_pkg::*;

   localparam int W      = cic_width(OSR_LOG2);
   localparam int SHIFT  = out_shift(OSR_LOG2);
   localparam int OSR_M1 = (1 << OSR_LOG2) - 1;
   // Full scale is 2^(W-1); it is the only value whose shifted form does not fit PCM_W bits.
   localparam logic [W-1:0] FULL_SCALE = {1'b1, {(W-1){1'b0}}};

   logic                b;
   logic                e;
   logic [OSR_LOG2-1:0] cnt_q, cnt_d;
   logic [W-1:0]        i1_q, i2_q, i3_q;
   logic [W-1:0]        i1_d, i2_d, i3_d;
   logic [W-1:0]        d1_q, d2_q, d3_q;
   logic [W-1:0]        c1, c2, y;
   logic                tick_q, tick_d;
   logic [PCM_W-1:0]    pcm_q, pcm_d;
   logic                pcm_valid_q;
   logic [1:0]          settle_q;
   logic                settled_q;

   pdm_in_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .bit_i (pdm_in),
      .en_i  (pdm_en),
      .bit_o (b),
      .en_o  (e)
   );

   always_comb begin
      i1_d   = i1_q;
      i2_d   = i2_q;
      i3_d   = i3_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (e) begin
         i1_d   = i1_q + W'(b);
         i2_d   = i2_q + i1_d;
         i3_d   = i3_q + i2_d;
         cnt_d  = cnt_q + 1'b1;
         tick_d = (cnt_q == OSR_LOG2'(OSR_M1));
      end
   end

   // Comb stage evaluates in the cycle after the tick, when i3_q already holds the frame total.
   always_comb begin
      c1    = i3_q - d1_q;
      c2    = c1 - d2_q;
      y     = c2 - d3_q;
      pcm_d = (y == FULL_SCALE) ? '1 : PCM_W'(y >> SHIFT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         i1_q        <= '0;
         i2_q        <= '0;
         i3_q        <= '0;
         d1_q        <= '0;
         d2_q        <= '0;
         d3_q        <= '0;
         tick_q      <= 1'b0;
         pcm_q       <= '0;
         pcm_valid_q <= 1'b0;
         settle_q    <= '0;
         settled_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         i1_q        <= i1_d;
         i2_q        <= i2_d;
         i3_q        <= i3_d;
         tick_q      <= tick_d;
         pcm_valid_q <= tick_q;
         if (tick_q) begin
            d1_q  <= i3_q;
            d2_q  <= c1;
            d3_q  <= c2;
            pcm_q <= pcm_d;
            if (settle_q != 2'd3) begin
               settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd2) begin
               settled_q <= 1'b1;
            end
         end
      end
   end

   assign pcm         = pcm_q;
   assign pcm_valid   = pcm_valid_q;
   assign pcm_settled = settled_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: reference is the sinc^3 impulse response applied to the strobed bit history.
module tb_pdm_decimator;

   localparam int L    = 6;
   localparam int S    = 2;
   localparam int OSR  = 1 << L;
   localparam int HLEN = 3 * (OSR - 1) + 1;
   localparam int SH   = 3 * L - 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pdm_in = 1'b0;
   logic        pdm_en = 1'b0;
   logic [15:0] pcm;
   logic        pcm_valid;
   logic        pcm_settled;

   always #5 clk = ~clk;

   pdm_decimator #(
      .OSR_LOG2    (L),
      .SYNC_STAGES (S)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pdm_in      (pdm_in),
      .pdm_en      (pdm_en),
      .pcm         (pcm),
      .pcm_valid   (pcm_valid),
      .pcm_settled (pcm_settled)
   );

   typedef struct {
      logic [3:0]  pat;
      logic [15:0] exp_settled;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   longint      h[HLEN];
   bit          bits[$];
   int          vcount;
   int          cyc = 0;
   int          last_valid_cyc;
   int          spacing_chk = 0;
   logic [15:0] samples[16];
   int          sd_acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected n-th output (1-based): convolution of the strobed bits with the CIC impulse response.
   function automatic logic [31:0] model_pcm(input int n);
      longint y = 0;
      for (int k = 0; k < HLEN; k++) begin
         int idx = n * OSR - 1 - k;
         if (idx >= 0 && idx < bits.size() && bits[idx]) y += h[k];
      end
      if (y == (longint'(1) << (3 * L))) return 32'hFFFF;
      return 32'(y >> SH) & 32'hFFFF;
   endfunction

   task automatic cycle(input logic b, input logic en);
      pdm_in = b;
      pdm_en = en;
      @(posedge clk);
      if (rst_n && en) bits.push_back(b);
      cyc++;
      #1;
      if (pcm_valid) begin
         vcount++;
         if (vcount < 16) samples[vcount] = pcm;
         check("pcm_vs_model", {16'h0, pcm}, model_pcm(vcount));
         check("settled_flag", {31'h0, pcm_settled}, (vcount >= 3) ? 32'd1 : 32'd0);
         if (spacing_chk != 0 && vcount > 1)
            check("valid_spacing", cyc - last_valid_cyc, spacing_chk);
         last_valid_cyc = cyc;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) cycle(1'b0, 1'b0);
      bits.delete();
      vcount = 0;
      sd_acc = 0;
      rst_n  = 1'b1;
   endtask

   // First-order sigma-delta source standing in for the modulator; advances only on strobes.
   function automatic logic sd_bit(input int level);
      sd_acc += level;
      if (sd_acc >= 65536) begin
         sd_acc -= 65536;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   initial begin
      vec_t vecs[5];
      longint box[OSR];
      longint tmp[2*OSR-1];
      int     n;
      int     vc0;
      logic   bb;
      logic   en;

      for (int i = 0; i < OSR; i++) box[i] = 1;
      for (int i = 0; i < 2*OSR-1; i++) tmp[i] = 0;
      for (int i = 0; i < OSR; i++)
         for (int j = 0; j < OSR; j++) tmp[i+j] += box[i] * box[j];
      for (int i = 0; i < HLEN; i++) h[i] = 0;
      for (int i = 0; i < 2*OSR-1; i++)
         for (int j = 0; j < OSR; j++) h[i+j] += tmp[i] * box[j];

      vecs[0] = '{4'b0000, 16'h0000};
      vecs[1] = '{4'b1111, 16'hFFFF};
      vecs[2] = '{4'b0101, 16'h8000};
      vecs[3] = '{4'b0001, 16'h4000};
      vecs[4] = '{4'b0111, 16'hC000};

      do_reset();
      check("reset_pcm", {16'h0, pcm}, 32'h0);
      check("reset_valid", {31'h0, pcm_valid}, 32'h0);
      check("reset_settled", {31'h0, pcm_settled}, 32'h0);

      foreach (vecs[v]) begin
         do_reset();
         for (int j = 0; j < 6 * OSR + S + 4; j++) cycle(vecs[v].pat[j % 4], 1'b1);
         check("tbl_valid_count", vcount, 6);
         check("tbl_settled_pcm", {16'h0, pcm}, {16'h0, vecs[v].exp_settled});
         check("tbl_settled_flag", {31'h0, pcm_settled}, 32'd1);
         if (vecs[v].pat == 4'b1111) begin
            check("step_sample1", {16'h0, samples[1]}, 32'h2CB0);
            check("step_sample2", {16'h0, samples[2]}, 32'hD750);
            check("step_sample3", {16'h0, samples[3]}, 32'hFFFF);
         end
      end

      // Mid-frame reset: three frames in, then 29 more strobes puts the counter at 30.
      do_reset();
      for (int j = 0; j < 400 && vcount < 3; j++) cycle(1'b1, 1'b1);
      repeat (29) cycle(1'b1, 1'b1);
      check("pre_reset_pcm", {16'h0, pcm}, 32'hFFFF);
      rst_n = 1'b0;
      cycle(1'b1, 1'b1);
      check("midrst_pcm", {16'h0, pcm}, 32'h0);
      check("midrst_valid", {31'h0, pcm_valid}, 32'h0);
      check("midrst_settled", {31'h0, pcm_settled}, 32'h0);
      bits.delete();
      vcount = 0;
      rst_n  = 1'b1;
      n = 1;
      while (!pcm_valid && n < 200) begin
         cycle(1'b1, 1'b1);
         n++;
      end
      check("first_valid_latency", n, OSR + S + 2);

      // One strobe every third cycle: frames stretch to 192 cycles.
      do_reset();
      spacing_chk = 3 * OSR;
      for (int j = 0; j < 6 * 3 * OSR + 10; j++) cycle(1'b1, (j % 3) == 0);
      spacing_chk = 0;
      check("sparse_valid_count", vcount, 6);
      check("sparse_pcm", {16'h0, pcm}, 32'hFFFF);
      vc0 = vcount;
      repeat (500) cycle(1'b1, 1'b0);
      check("en_low_no_valid", vcount, vc0);

      // Random levels through a sigma-delta source with random strobe gaps.
      do_reset();
      for (int seg = 0; seg < 4; seg++) begin
         int level;
         level = (seg == 0) ? 32'h4000 : $urandom_range(32'h0800, 32'hF800);
         for (int j = 0; j < 20 * OSR; j++) begin
            en = ($urandom_range(0, 9) < 8);
            bb = en ? sd_bit(level) : 1'($urandom_range(0, 1));
            cycle(bb, en);
         end
         check("loop_within_tol", ((int'(pcm) - level) <= 256 && (level - int'(pcm)) <= 256), 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
